// File: rtl/zi_sched_pkg.sv
// Shared types and helpers for the zero-insert scheduler slice.
package zi_sched_pkg;

    typedef enum logic [1:0] {
        SM_INIT       = 2'd0,
        SM_ARB        = 2'd1,
        SM_PASS_DATA  = 2'd2,
        SM_PASS_ZEROS = 2'd3
    } state_t;

    // Index width for n channels; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zero_insert_scheduler_if.sv
// Multi-channel sample input and tagged sample output of the zero-insert scheduler.
interface zero_insert_scheduler_if
    import zi_sched_pkg::*;
#(
    parameter int G_DWIDTH = 24,
    parameter int G_NUM_CH = 4
);
    localparam int CH_W = ch_w(G_NUM_CH);

    logic [G_NUM_CH*G_DWIDTH-1:0] din;
    logic [G_NUM_CH-1:0]          din_valid;
    logic [G_NUM_CH-1:0]          din_ready;
    logic [G_DWIDTH-1:0]          dout;
    logic [CH_W-1:0]              dout_ch;
    logic                         dout_first;
    logic                         dout_valid;
    logic                         dout_ready;

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_ch, dout_first, dout_valid
    );

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_ch, dout_first, dout_valid
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any_req
);
    // Scan upward from ptr and keep the first requester found.
    always_comb begin
        int idx;
        logic [W-1:0] idx_w;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            idx_w = W'(idx);
            if (!any_req && req[idx_w]) begin
                any_req = 1'b1;
                grant   = idx_w;
            end
        end
    end
endmodule

// File: rtl/zero_insert_scheduler.sv
// Round-robin scheduler sharing one zero-insertion upsampler across G_NUM_CH
// streams. Each grant forwards one sample then rate-1 zeros tagged with the
// channel id. Optional build macro ZI_SCHED_LOCKSTEP_EN serves channels strictly
// in order 0..N-1, starting a round only when every channel is valid.
//
// state         | meaning
// SM_INIT       | one idle cycle after reset/disable, outputs low
// SM_ARB        | pick next channel, latch upsample rate
// SM_PASS_DATA  | forward granted sample combinationally
// SM_PASS_ZEROS | emit rate_q-1 zero beats tagged with grant
module zero_insert_scheduler
    import zi_sched_pkg::*;
#(
    parameter int G_DWIDTH = 24,
    parameter int G_NUM_CH = 4,
    parameter int G_RATE_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [G_RATE_W-1:0] upsample_rate,
    zero_insert_scheduler_if.slave bus
);
    localparam int CH_W = ch_w(G_NUM_CH);

    state_t              state, state_nxt;
    logic [CH_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [CH_W-1:0]     grant_q, grant_nxt;
    logic [CH_W-1:0]     arb_grant, ptr_inc;
    logic [G_RATE_W-1:0] rate_q, rate_nxt;
    logic [G_RATE_W-1:0] zero_cnt, zero_cnt_nxt;
    logic                arb_any, arb_ok;

    rr_arbiter #(.N(G_NUM_CH), .W(CH_W)) u_arb (
        .req     (bus.din_valid),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

`ifdef ZI_SCHED_LOCKSTEP_EN
    // A frame starts only once all channels are ready; later slots wait on their own channel.
    assign arb_ok = arb_any && ((rr_ptr == '0) ? (&bus.din_valid) : bus.din_valid[rr_ptr]);
`else
    assign arb_ok = arb_any;
`endif

    assign ptr_inc = (grant_q == CH_W'(G_NUM_CH - 1)) ? '0 : grant_q + 1'b1;

    // Next-state, burst bookkeeping and beat outputs.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        grant_nxt      = grant_q;
        rate_nxt       = rate_q;
        zero_cnt_nxt   = zero_cnt;
        bus.din_ready  = '0;
        bus.dout       = '0;
        bus.dout_ch    = '0;
        bus.dout_first = 1'b0;
        bus.dout_valid = 1'b0;
        case (state)
            SM_INIT: state_nxt = SM_ARB;
            SM_ARB: begin
                if (arb_ok) begin
                    grant_nxt = arb_grant;
                    rate_nxt  = upsample_rate;
                    state_nxt = SM_PASS_DATA;
                end
            end
            SM_PASS_DATA: begin
                bus.dout               = bus.din[grant_q*G_DWIDTH +: G_DWIDTH];
                bus.dout_ch            = grant_q;
                bus.dout_first         = 1'b1;
                bus.dout_valid         = bus.din_valid[grant_q];
                bus.din_ready[grant_q] = bus.dout_ready;
                if (bus.din_valid[grant_q] && bus.dout_ready) begin
                    rr_ptr_nxt = ptr_inc;
                    if (rate_q <= G_RATE_W'(1)) begin
                        state_nxt = SM_ARB;
                    end else begin
                        zero_cnt_nxt = G_RATE_W'(1);
                        state_nxt    = SM_PASS_ZEROS;
                    end
                end
            end
            SM_PASS_ZEROS: begin
                bus.dout_valid = 1'b1;
                bus.dout_ch    = grant_q;
                if (bus.dout_ready) begin
                    if (zero_cnt == rate_q - G_RATE_W'(1)) state_nxt = SM_ARB;
                    else zero_cnt_nxt = zero_cnt + G_RATE_W'(1);
                end
            end
            default: state_nxt = SM_INIT;
        endcase
        // Disable wins over any handshake in the same cycle.
        if (!enable) begin
            state_nxt    = SM_INIT;
            rr_ptr_nxt   = '0;
            zero_cnt_nxt = '0;
        end
    end

    // State and burst registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SM_INIT;
            rr_ptr   <= '0;
            grant_q  <= '0;
            rate_q   <= '0;
            zero_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_q  <= grant_nxt;
            rate_q   <= rate_nxt;
            zero_cnt <= zero_cnt_nxt;
        end
    end
endmodule

// File: doc/zero_insert_scheduler.md
# zero_insert_scheduler

Round-robin scheduler that shares one zero-insertion upsampler datapath between G_NUM_CH independent sample streams in the tulip DSP chain. Each grant accepts one sample from the selected channel, forwards it, then emits rate-1 zero samples tagged with that channel's id before it arbitrates again. The downstream interpolation filter bank uses the tag to select per-channel coefficient/state memory.

## Interface
- G_DWIDTH, 24: sample width.
- G_NUM_CH, 4: number of requesting channels, 2..16.
- G_RATE_W, 4: width of the runtime upsample-rate field.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  0 = synchronous return to SM_INIT; in-flight burst is abandoned.
- upsample_rate  in  G_RATE_W  zeros-per-sample + 1; sampled at grant; 0 and 1 both mean no zeros.
- din  in  G_NUM_CH*G_DWIDTH  channel c occupies bits [c*G_DWIDTH +: G_DWIDTH].
- din_valid  in  G_NUM_CH  per-channel valid.
- din_ready  out  G_NUM_CH  per-channel ready; at most one bit high.
- dout  out  G_DWIDTH  sample or zero.
- dout_ch  out  $clog2(G_NUM_CH)  channel tag of current beat.
- dout_first  out  1  high on the data beat of a burst.
- dout_valid  out  1  output valid.
- dout_ready  in  1  downstream ready.

## Operation
- States: SM_INIT -> SM_ARB -> SM_PASS_DATA -> SM_PASS_ZEROS -> SM_ARB.
- SM_INIT: one cycle, then SM_ARB; all outputs low.
- SM_ARB: if any din_valid bit is set, register grant = first requesting channel at or after rr_ptr (wrapping), latch rate_q = upsample_rate, go to SM_PASS_DATA. Otherwise stay.
- SM_PASS_DATA: dout = granted din, dout_valid = din_valid[grant], din_ready[grant] = dout_ready, dout_first = 1. On handshake: rr_ptr <= grant+1 (wrap to 0 at G_NUM_CH); if rate_q <= 1 go to SM_ARB, else zero_cnt <= 1 and go to SM_PASS_ZEROS.
- SM_PASS_ZEROS: dout = 0, dout_valid = 1, din_ready = 0, dout_ch = grant. On handshake, if zero_cnt == rate_q-1 go to SM_ARB, else increment zero_cnt.
- Grant and rate_q are held for the whole burst; upsample_rate changes mid-burst do not take effect until the next grant.
- Channel valid that drops in SM_PASS_DATA before the handshake: stay in SM_PASS_DATA and keep the grant (no re-arbitration).
- enable=0 or reset_n=0: state SM_INIT, rr_ptr 0, zero_cnt 0; enable has priority over handshakes in that cycle.

## Timing
- Reset values: din_ready 0, dout 0, dout_ch 0, dout_first 0, dout_valid 0.
- The data beat is combinational from din to dout, with no added register latency. din_ready is combinational from dout_ready.
- Arbitration costs one idle cycle per burst (SM_ARB). Back-to-back bursts with dout_ready=1 take rate_q+1 cycles each; with rate_q <= 1 they take 2 cycles each.
- dout_valid must not deassert once asserted in SM_PASS_ZEROS until the handshake. dout and dout_ch are stable while dout_valid=1 and dout_ready=0.

## Configuration
- ZI_SCHED_LOCKSTEP_EN defined: SM_ARB grants only when rr_ptr == 0 and all din_valid bits are set, or when rr_ptr != 0 and din_valid[rr_ptr] is set. Channels are then served strictly 0,1,..,N-1 with no skipping, which keeps frames aligned.
- ZI_SCHED_LOCKSTEP_EN undefined: work-conserving round-robin as described above, and idle channels are skipped.

## Structure
- Package zi_sched_pkg: state_t enum (SM_INIT, SM_ARB, SM_PASS_DATA, SM_PASS_ZEROS) and function ch_w(n) returning $clog2 with a minimum of 1.
- Sub-module rr_arbiter: a combinational priority pick from a request vector and a pointer, returning grant index and any_req. It is reused by other multi-channel blocks.

## Test plan
- N=4, rate=4, all channels valid with values 0x10,0x20,0x30,0x40, dout_ready=1 -> output is 0x10,0,0,0 tagged ch0, then ch1..ch3 in the same pattern, with one idle cycle between bursts.
- rate=1, only ch2 valid -> dout=din[2] every 2 cycles, no zeros, dout_ch=2, dout_first=1 on each beat.
- rate=3 with dout_ready toggling 1,0,1,0 -> each zero is held through stall cycles, and exactly 2 zeros are emitted per sample.
- upsample_rate changed 4→2 during the zeros of ch0 -> ch0 still emits 3 zeros; the ch1 burst emits 1 zero.
- enable dropped on the 2nd zero of ch1 -> outputs go to 0 the next cycle and rr_ptr resets. After re-enable, ch0 is served first.
- LOCKSTEP_EN with only ch0..ch2 valid -> no grant is issued. Raising ch3 valid -> ch0 is served first, followed in order by ch1, ch2 and ch3.
